pipe_stage_rg: RTL and testbench
================================

Name: pipe_stage_rg

Overview:
Parametrised pipeline-stage register. It is the successor to the fixed-field stage registers between CPU pipeline stages.
- Carries an opaque DATA_W payload with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer, so upstream ready is registered.
- Stage-specific wrappers (IF/ID, ID/EX, EX/MEM, MEM/WB) pack their fields into in_data and instantiate this block.

Parameters:
DATA_W, 32, payload width in bits (>=1)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
RST_VAL, '0, payload value loaded into the data registers on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all held and incoming entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_data  in  DATA_W  upstream payload
out_valid  out  1  entry presented downstream
out_ready  in  1  downstream accepts
out_data  out  DATA_W  payload presented downstream
count  out  2  entries held (0..2)

Behaviour:
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Transfers happen only on fire.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Sustained throughput is 1 entry/cycle.
- Reset (rst_n low, async):
  - state=EMPTY, out_valid=0, count=0, data registers=RST_VAL, out_data=RST_VAL.
  - in_ready=1 when SKID=1 (registered); in_ready=1 when SKID=0 (derived).
  - Reset mid-transfer discards all entries. Deassertion is taken synchronously to clk by the upstream reset synchroniser.
- SKID=1 state machine (main reg drives out_data; skid reg is the overflow):
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE, in_fire & out_fire -> ONE, main<=in_data.
  - ONE, in_fire & !out_fire -> TWO, skid<=in_data.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> ONE.
  - TWO: in_ready=0, so there is no in_fire. out_fire -> ONE, main<=skid. Otherwise hold.
  - in_ready is a flop: 1 in EMPTY and ONE, 0 in TWO. It has no combinational path from out_ready.
- SKID=0:
  - Single main register; in_ready = !out_valid | out_ready.
  - in_fire loads main and sets out_valid=1. out_fire without in_fire clears out_valid.
  - TWO is unreachable; count<=1.
- Outputs:
  - out_valid = (state != EMPTY).
  - count = 0, 1 or 2 for EMPTY, ONE, TWO.
- Flush (highest priority, synchronous):
  - Next state=EMPTY and out_valid=0 on the next cycle.
  - An in_fire in the same cycle is discarded; an out_fire in the same cycle still counts as delivered.
  - in_ready=1 on the next cycle. Data registers keep their contents (don't-care while invalid).
- Stability: while out_valid & !out_ready, out_data and out_valid hold unchanged.
- Ordering: entries leave in arrival order; no duplication, no loss except on flush or reset.
- in_data is sampled only on in_fire; X on in_data when in_fire=0 must not propagate.

Decomposition:
- pipe_pkg holds the typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t and a localparam for the count width.
- No sub-module: main and skid registers plus the FSM stay inline. Per-stage field packing lives in the thin wrapper modules, not here.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, count=0, in_ready=1. Release rst_n, then present one entry -> out_valid=1 and out_data=32'hDEAD_BEEF one cycle later.
- Streaming: SKID=1, out_ready=1, push 0x1..0x8 back-to-back -> outputs 0x1..0x8 on consecutive cycles, one cycle late; count stays 1; in_ready never drops.
- Backpressure: SKID=1, out_ready=0, push 0xA then 0xB -> count=2, in_ready=0 on the cycle after 0xB. Raise out_ready for 2 cycles -> 0xA then 0xB delivered, count=0, in_ready=1 again.
- Flush: with count=2, assert flush together with in_valid=1 and in_data=0xC -> next cycle out_valid=0, count=0, in_ready=1; 0xC never appears at the output.
- SKID=0: out_ready=0 with one entry held -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally, and a new entry replaces the old in the same cycle with no bubble.
- Async reset mid-stream: drop rst_n between clock edges with count=2 -> out_valid=0 immediately, with no wait for clk; no stale entries emerge after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and count helper for pipe_stage_rg
package pipe_pkg;

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Occupancy reported downstream for each state.
  function automatic logic [CNT_W-1:0] state_count(input pipe_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_rg.sv
// rtl/pipe_stage_rg.sv - parametrised valid/ready pipeline stage register with optional skid buffer
module pipe_stage_rg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                SKID    = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire;
  logic              out_fire;

  // With a skid buffer upstream ready comes straight from a flop; without
  // one it is derived so a held entry can be replaced in the same cycle.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_q;
  assign count     = state_count(state_q);

  // Next-state and payload routing; flush wins over any handshake. In the
  // single-register build TWO is unreachable because in_ready is low in ONE
  // whenever the downstream side is stalled.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  // State, payload and registered ready; reset discards every held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= RST_VAL;
      skid_q     <= RST_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_rg.sv
// tb/tb_pipe_stage_rg.sv - scoreboard bench for pipe_stage_rg in skid and single-register builds
module tb_pipe_stage_rg;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_count;

  logic        f_flush, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic [31:0] f_in_data, f_out_data;
  logic [1:0]  f_count;

  logic [31:0] sq[$];
  logic [31:0] fq[$];
  logic [31:0] exp_v;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_rg #(.DATA_W(32), .SKID(1), .RST_VAL(32'h0)) u_dut_skid (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count)
  );

  pipe_stage_rg #(.DATA_W(32), .SKID(0), .RST_VAL(32'h0)) u_dut_flow (
    .clk(clk), .rst_n(rst_n), .flush(f_flush),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
    .count(f_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable at the falling edge, so the fires seen
  // here are the ones the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      sq.delete();
      fq.delete();
    end else begin
      if (s_out_valid && s_out_ready) begin
        if (sq.size() == 0) check("s_sb_underflow", sq.size(), 1);
        else begin
          exp_v = sq.pop_front();
          check("s_sb_data", s_out_data, exp_v);
        end
      end
      if (s_flush) sq.delete();
      else if (s_in_valid && s_in_ready) sq.push_back(s_in_data);

      if (f_out_valid && f_out_ready) begin
        if (fq.size() == 0) check("f_sb_underflow", fq.size(), 1);
        else begin
          exp_v = fq.pop_front();
          check("f_sb_data", f_out_data, exp_v);
        end
      end
      if (f_flush) fq.delete();
      else if (f_in_valid && f_in_ready) fq.push_back(f_in_data);
    end
  end

  initial begin
    rst_n       = 1'b0;
    s_flush     = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 32'hDEAD_BEEF;
    s_out_ready = 1'b0;
    f_flush     = 1'b0;
    f_in_valid  = 1'b0;
    f_in_data   = 32'h0;
    f_out_ready = 1'b0;

    // Reset held with a valid entry at the input
    #12;
    check("rst_out_valid", {31'd0, s_out_valid}, 32'd0);
    check("rst_out_data", s_out_data, 32'h0);
    check("rst_count", {30'd0, s_count}, 32'd0);
    check("rst_in_ready", {31'd0, s_in_ready}, 32'd1);
    check("rst_f_in_ready", {31'd0, f_in_ready}, 32'd1);
    check("rst_f_out_valid", {31'd0, f_out_valid}, 32'd0);

    step();
    rst_n = 1'b1;
    step();
    s_in_valid = 1'b0;
    check("first_out_valid", {31'd0, s_out_valid}, 32'd1);
    check("first_out_data", s_out_data, 32'hDEAD_BEEF);
    s_out_ready = 1'b1;
    step();
    check("first_drained", {31'd0, s_out_valid}, 32'd0);

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = i;
      check("stream_in_ready", {31'd0, s_in_ready}, 32'd1);
      if (i > 1) begin
        check("stream_out_valid", {31'd0, s_out_valid}, 32'd1);
        check("stream_count", {30'd0, s_count}, 32'd1);
        check("stream_out_data", s_out_data, i - 1);
      end
      step();
    end
    s_in_valid = 1'b0;
    check("stream_last", s_out_data, 32'd8);
    step();
    check("stream_empty", {30'd0, s_count}, 32'd0);

    // Backpressure fills the skid entry
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 32'hA;
    step();
    s_in_data   = 32'hB;
    step();
    s_in_valid  = 1'b0;
    check("bp_count2", {30'd0, s_count}, 32'd2);
    check("bp_in_ready", {31'd0, s_in_ready}, 32'd0);
    check("bp_hold_data", s_out_data, 32'hA);
    step();
    check("bp_stable", s_out_data, 32'hA);
    s_out_ready = 1'b1;
    step();
    check("bp_count1", {30'd0, s_count}, 32'd1);
    check("bp_second", s_out_data, 32'hB);
    step();
    check("bp_count0", {30'd0, s_count}, 32'd0);
    check("bp_ready_back", {31'd0, s_in_ready}, 32'd1);

    // Flush while full, with an entry offered in the same cycle
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 32'hD;
    step();
    s_in_data   = 32'hE;
    step();
    check("fl_pre_count", {30'd0, s_count}, 32'd2);
    s_flush    = 1'b1;
    s_in_data  = 32'hC;
    step();
    s_flush    = 1'b0;
    s_in_valid = 1'b0;
    check("fl_out_valid", {31'd0, s_out_valid}, 32'd0);
    check("fl_count", {30'd0, s_count}, 32'd0);
    check("fl_in_ready", {31'd0, s_in_ready}, 32'd1);
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_c", {31'd0, s_out_valid}, 32'd0);
    end

    // Single-register build: combinational ready and no-bubble replacement
    f_in_valid = 1'b1;
    f_in_data  = 32'h11;
    step();
    f_in_valid = 1'b0;
    check("f_valid", {31'd0, f_out_valid}, 32'd1);
    check("f_ready_stall", {31'd0, f_in_ready}, 32'd0);
    check("f_count", {30'd0, f_count}, 32'd1);
    f_out_ready = 1'b1;
    #1;
    check("f_ready_comb", {31'd0, f_in_ready}, 32'd1);
    f_in_valid = 1'b1;
    f_in_data  = 32'h22;
    step();
    f_in_valid = 1'b0;
    check("f_replace_data", f_out_data, 32'h22);
    check("f_replace_valid", {31'd0, f_out_valid}, 32'd1);
    check("f_replace_count", {30'd0, f_count}, 32'd1);
    step();
    check("f_drained", {31'd0, f_out_valid}, 32'd0);

    // Asynchronous reset between edges with two entries held
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 32'h31;
    step();
    s_in_data   = 32'h32;
    step();
    s_in_valid  = 1'b0;
    check("ar_pre_count", {30'd0, s_count}, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'd0, s_out_valid}, 32'd0);
    check("ar_count", {30'd0, s_count}, 32'd0);
    check("ar_in_ready", {31'd0, s_in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_no_stale", {31'd0, s_out_valid}, 32'd0);
    end

    check("s_sb_drain", sq.size(), 0);
    check("f_sb_drain", fq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
